// File: rtl/display16_driver.sv
// ---------------------------------------------------------------------------
// display16_driver
//   Output stage for the 16-segment message sequencer. Accepts one segment
//   pattern per character over a valid/ready handshake. It shows the pattern
//   for DWELL_CYCLES clocks, then forces a blank gap of GAP_CYCLES clocks so
//   that repeated characters stay visually distinct. PWM brightness and panel
//   polarity are applied in front of a registered panel drive.
//
// Ports
//   clk        : system clock, all state on the rising edge
//   rst        : asynchronous active-low reset
//   seg_in     : segment pattern from the sequencer, bit=1 means segment lit
//   seg_valid  : seg_in holds a valid character
//   seg_ready  : driver accepts a character this cycle (IDLE only)
//   hold       : freezes the dwell countdown while a character is shown
//   brightness : PWM duty level, sampled every cycle (all ones = 100 %)
//   sal        : registered panel drive, polarity set by COMMON_ANODE
//   busy       : high while a character is shown or the gap is running
// ---------------------------------------------------------------------------
module display16_driver #(
  parameter int DWELL_CYCLES = 1000,
  parameter int GAP_CYCLES   = 100,
  parameter int PWM_BITS     = 4,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         seg_in,
  input  logic                seg_valid,
  output logic                seg_ready,
  input  logic                hold,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [15:0]         sal,
  output logic                busy
);

  // One shared down-counter serves both dwell and gap timing.
  localparam int CNT_SPAN  = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int CNT_RANGE = (CNT_SPAN > 2) ? CNT_SPAN : 2;
  localparam int CW        = $clog2(CNT_RANGE);

  localparam logic [CW-1:0]       DWELL_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0]       GAP_LOAD   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [15:0]         BLANK      = {16{COMMON_ANODE}};
  localparam logic [PWM_BITS-1:0] FULL_ON    = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [15:0]         pattern_q, pattern_d;
  logic [PWM_BITS-1:0] pwm_q;
  logic [15:0]         sal_q, sal_d;
  logic                armed_q;   // low during reset, high from the first clock after release
  logic                pwm_on;
  logic [15:0]         lit;

  // All-ones brightness must give 100 % duty, which the compare alone cannot.
  assign pwm_on = (pwm_q < brightness) || (brightness == FULL_ON);

  assign seg_ready = armed_q && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign sal       = sal_q;

  // Next-state and panel-drive logic.
  // NOTE: every output of this block gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pattern_d = pattern_q;
    lit       = 16'h0000;

    unique case (state_q)
      S_IDLE: begin
        if (seg_valid && seg_ready) begin
          pattern_d = seg_in;
          cnt_d     = DWELL_LOAD;
          state_d   = S_SHOW;
        end
      end

      S_SHOW: begin
        if (pwm_on) begin
          lit = pattern_q;
        end
        if (!hold) begin
          if (cnt_q == '0) begin
            if (GAP_CYCLES > 0) begin
              cnt_d   = GAP_LOAD;
              state_d = S_GAP;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end

      S_GAP: begin
        // hold has no effect here: the gap always runs its full length.
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Polarity is applied last so "blank" is all segments off on either panel.
    sal_d = lit ^ BLANK;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pattern_q <= 16'h0000;
      pwm_q     <= '0;
      sal_q     <= BLANK;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pattern_q <= pattern_d;
      pwm_q     <= pwm_q + 1'b1;
      sal_q     <= sal_d;
      armed_q   <= 1'b1;
    end
  end

endmodule
